// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/and/or/xor with operand zero/negate modifiers,
// plus an optional shift-add multiply taking WIDTH+1 cycles. Valid/ready on both sides.
module alu_seq #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic [2:0]       op,
    input  logic             no,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             neg,
    output logic             carry,
    output logic             ovf,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nx;

    logic               accept;
    logic               op_mul;
    logic [WIDTH-1:0]   xp, yp;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   sc_r, sc_out;
    logic               sc_carry, sc_ovf, sc_err;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic               mul_no;
    logic               mul_done;
    logic [WIDTH-1:0]   mul_out;
    logic               mul_carry;

    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign op_mul    = MUL_EN && (op == OP_MUL);
    assign mul_done  = (state == BUSY) && (cnt == '0);

    // Operand prep: zero first, then negate.
    always_comb begin
        xp = zx ? '0 : x;
        if (nx) xp = ~xp;
        yp = zy ? '0 : y;
        if (ny) yp = ~yp;
    end

    assign sum = {1'b0, xp} + {1'b0, yp} + {{WIDTH{1'b0}}, cin};

    // NOTE: every output of this block gets a default before the case, so no latch is inferred.
    always_comb begin
        sc_r     = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        sc_err   = 1'b0;
        case (op)
            OP_ADD: begin
                sc_r     = sum[WIDTH-1:0];
                sc_carry = sum[WIDTH];
                sc_ovf   = (xp[WIDTH-1] == yp[WIDTH-1]) && (sum[WIDTH-1] != xp[WIDTH-1]);
            end
            OP_AND:  sc_r = xp & yp;
            OP_OR:   sc_r = xp | yp;
            OP_XOR:  sc_r = xp ^ yp;
            default: sc_err = 1'b1;
        endcase
        // Illegal ops report a clean zero result regardless of the negate bit.
        sc_out = sc_err ? '0 : (no ? ~sc_r : sc_r);
    end

    assign mul_out   = mul_no ? ~acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign mul_carry = |acc[2*WIDTH-1:WIDTH];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = op_mul ? BUSY : HOLD;
            BUSY: if (mul_done) state_nx = HOLD;
            HOLD: begin
                if (accept)         state_nx = op_mul ? BUSY : HOLD;
                else if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: registered state is always assigned non-blocking so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out    <= '0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            err    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            mul_no <= 1'b0;
        end else if (accept) begin
            if (op_mul) begin
                mcand  <= {{WIDTH{1'b0}}, xp};
                mplier <= yp;
                acc    <= '0;
                cnt    <= CW'(WIDTH);
                mul_no <= no;
            end else begin
                out   <= sc_out;
                zero  <= (sc_out == '0);
                neg   <= sc_out[WIDTH-1];
                carry <= sc_carry;
                ovf   <= sc_ovf;
                err   <= sc_err;
            end
        end else if (state == BUSY) begin
            if (cnt == '0) begin
                out   <= mul_out;
                zero  <= (mul_out == '0);
                neg   <= mul_out[WIDTH-1];
                carry <= mul_carry;
                ovf   <= 1'b0;
                err   <= 1'b0;
            end else begin
                // One multiplier bit per cycle, LSB first.
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=16, MUL_EN=1) with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] x, y;
    logic        zx, nx, zy, ny;
    logic [2:0]  op;
    logic        no;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        zero, neg, carry, ovf, err;

    int total = 0;
    int bad   = 0;

    alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .zx        (zx),
        .nx        (nx),
        .zy        (zy),
        .ny        (ny),
        .op        (op),
        .no        (no),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .neg       (neg),
        .carry     (carry),
        .ovf       (ovf),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected flags packed as {zero, neg, carry, ovf, err}.
    task automatic check_res(input string tag, input logic [15:0] eo, input logic [4:0] ef);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".out"},   64'(out),       64'(eo));
        check({tag, ".flags"}, 64'({zero, neg, carry, ovf, err}), 64'(ef));
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                         input logic zxi, input logic nxi, input logic zyi, input logic nyi,
                         input logic noi, input logic cini);
        x = a; y = b; op = o;
        zx = zxi; nx = nxi; zy = zyi; ny = nyi;
        no = noi; cin = cini;
        in_valid = 1'b1;
    endtask

    initial begin
        int  n;
        bit  seen;

        rst = 1'b1;
        out_ready = 1'b1;
        // A bundle offered during reset must be ignored.
        drive(16'h0005, 16'h0003, 3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.out",   64'(out),       64'd0);
        check("rst.flags", 64'({zero, neg, carry, ovf, err}), 64'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // Add, then back-to-back single-cycle ops, one result per cycle.
        drive(16'h0005, 16'h0003, 3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        check_res("add", 16'h0008, 5'b00000);
        drive(16'h7FFF, 16'h0001, 3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        check_res("add_ovf", 16'h8000, 5'b01010);
        drive(16'hFFFF, 16'h0001, 3'b000, 0, 0, 0, 0, 0, 0);
        tick();
        check_res("add_wrap", 16'h0000, 5'b10100);
        drive(16'h1234, 16'h0005, 3'b000, 1, 1, 0, 0, 0, 0);
        tick();
        check_res("add_zxnx", 16'h0004, 5'b00100);
        drive(16'h00FF, 16'h0F0F, 3'b001, 0, 0, 0, 0, 1, 0);
        tick();
        check_res("and_no", 16'hFFF0, 5'b01000);
        drive(16'h00FF, 16'h0F0F, 3'b011, 0, 0, 0, 0, 0, 1);
        tick();
        check_res("xor_cin", 16'h0FF0, 5'b00000);
        drive(16'h0005, 16'h0003, 3'b000, 0, 0, 0, 1, 0, 1);
        tick();
        check_res("sub_ny_cin", 16'h0002, 5'b00100);
        drive(16'h00A5, 16'h1234, 3'b010, 0, 0, 1, 1, 0, 0);
        tick();
        check_res("or_zyny", 16'hFFFF, 5'b01000);
        in_valid = 1'b0;
        tick();
        check("idle.valid", 64'(out_valid), 64'd0);

        // Multiply with the consumer stalled and a bundle offered during BUSY.
        out_ready = 1'b0;
        drive(16'h0012, 16'h0034, 3'b100, 0, 0, 0, 0, 0, 0);
        tick();
        drive(16'h0001, 16'h0001, 3'b000, 0, 0, 0, 0, 0, 0);
        check("mul1.busy0", 64'({out_valid, in_ready}), 64'd0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("mul1.busy%0d", i), 64'({out_valid, in_ready}), 64'd0);
        end
        tick();
        check_res("mul1", 16'h03A8, 5'b00000);

        // Backpressure: result held, nothing accepted.
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("bp%0d.in_ready", i), 64'(in_ready), 64'd0);
            check_res($sformatf("bp%0d", i), 16'h03A8, 5'b00000);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release.in_ready", 64'(in_ready), 64'd1);
        tick();
        check_res("bp.next", 16'h0002, 5'b00000);

        // Multiply accepted in the same cycle the previous result is consumed.
        drive(16'h0100, 16'h0100, 3'b100, 0, 0, 0, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("mul2.latency", 64'(n), 64'd17);
        check_res("mul2", 16'h0000, 5'b10100);
        tick();
        check("mul2.drain", 64'(out_valid), 64'd0);

        // Reset on cycle 8 of a multiply aborts it.
        drive(16'h0012, 16'h0034, 3'b100, 0, 0, 0, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.out",   64'(out), 64'd0);
        check("abort.flags", 64'({out_valid, zero, neg, carry, ovf, err}), 64'd0);
        #1;
        check("abort.in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("abort.never_valid", 64'(seen), 64'd0);

        // Illegal op: zero result with err, negate bit has no effect.
        drive(16'h1234, 16'h5678, 3'b110, 0, 0, 0, 0, 1, 1);
        tick();
        in_valid = 1'b0;
        check_res("illegal", 16'h0000, 5'b10001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
